// File: rtl/return_addr_stack_pkg.sv
// Shared constants for the return-address stack and its users in decode.
package return_addr_stack_pkg;

    // Default number of stack entries.
    localparam int unsigned RAS_DEPTH_DEFAULT = 8;

    // Register number of $ra; decode only raises pop for `jr` through this register.
    localparam int unsigned REG_RA = 31;

    // Width of the optional statistics counters.
    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/return_addr_stack_if.sv
// Decode/IFU-facing signal bundle for the return-address stack.
interface return_addr_stack_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             push;
    logic [WIDTH-1:0] push_addr;
    logic             pop;
    logic             flush;
    logic [WIDTH-1:0] top_addr;
    logic             top_valid;
    logic [PTR_W:0]   count;
    logic             full;
    logic [15:0]      overflow_cnt;
    logic [15:0]      underflow_cnt;

    // Decode/IFU side.
    modport master (
        output push, push_addr, pop, flush,
        input  top_addr, top_valid, count, full, overflow_cnt, underflow_cnt
    );

    // Stack side.
    modport slave (
        input  push, push_addr, pop, flush,
        output top_addr, top_valid, count, full, overflow_cnt, underflow_cnt
    );
endinterface

// File: rtl/return_addr_stack_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] value_o
);
    logic [W-1:0] value_q, value_d;

    // Count up on each event, holding at all-ones.
    always_comb begin
        value_d = value_q;
        if (inc_i && (value_q != '1)) begin
            value_d = value_q + W'(1);
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
endmodule

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push on call, pop on return, flush on redirect.
// Optional overflow/underflow statistics are built when RAS_STATS_EN is defined.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
    input logic                clk,
    input logic                rst_n,
    return_addr_stack_if.slave bus_io
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             full;
    logic             empty;

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);

    // Next-state for pointer/count and the array write; flush beats push/pop.
    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tos_q + PTR_W'(1);
        if (bus_io.flush) begin
            count_d = '0;
        end else if (bus_io.push && (!bus_io.pop || empty)) begin
            // Plain push; a push+pop on an empty stack degenerates to this too.
            tos_d  = tos_q + PTR_W'(1);
            wr_en  = 1'b1;
            wr_idx = tos_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + (PTR_W + 1)'(1);
            end
        end else if (bus_io.push && bus_io.pop) begin
            // Tail call: replace the top entry in place.
            wr_en  = 1'b1;
            wr_idx = tos_q;
        end else if (bus_io.pop && !empty) begin
            tos_d   = tos_q - PTR_W'(1);
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tos_q   <= '0;
            count_q <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents survive reset, writes are blocked during it.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_idx] <= bus_io.push_addr;
        end
    end

    assign bus_io.top_addr  = empty ? '0 : mem_q[tos_q];
    assign bus_io.top_valid = !empty;
    assign bus_io.count     = count_q;
    assign bus_io.full      = full;

`ifdef RAS_STATS_EN
    logic ovf_evt;
    logic unf_evt;

    assign ovf_evt = !bus_io.flush && bus_io.push && !bus_io.pop && full;
    assign unf_evt = !bus_io.flush && bus_io.pop && !bus_io.push && empty;

    sat_counter #(.W(STAT_W)) u_ovf_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (ovf_evt),
        .value_o (bus_io.overflow_cnt)
    );

    sat_counter #(.W(STAT_W)) u_unf_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (unf_evt),
        .value_o (bus_io.underflow_cnt)
    );
`else
    assign bus_io.overflow_cnt  = '0;
    assign bus_io.underflow_cnt = '0;
`endif
endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Parametrised hardware return-address stack (RAS) for the MIPS core.
- Pushes the link address on every `jal`/`jalr` and pops it on `jr $ra`, giving the fetch unit a predicted return target without a register-file read.
- Sits beside the IFU. Decode drives `push`/`pop`; the IFU consumes `top_addr`/`top_valid`.
- Generalises the single `$ra` link register to a DEPTH-entry circular stack with overflow wrap, flush and optional statistics.

Parameters:
- WIDTH, 32, address width in bits.
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- push  in  1  call seen (`jal`/`jalr`); push `push_addr`.
- push_addr  in  WIDTH  link address (PC+4 of the call).
- pop  in  1  return seen (`jr $ra`); pop the top entry.
- flush  in  1  discard all entries (exception or redirect).
- top_addr  out  WIDTH  current top entry, combinational from state.
- top_valid  out  1  stack non-empty.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow_cnt  out  16  overwrite-on-full events (RAS_STATS_EN only).
- underflow_cnt  out  16  pop-while-empty events (RAS_STATS_EN only).

Behaviour:
- Storage: DEPTH x WIDTH array, `tos` pointer (PTR_W bits, wraps modulo DEPTH), `count` register.
- Reset (rst_n low at rising edge): `tos`=0, `count`=0, stats=0. Array contents are not reset.
  - Outputs after reset: `top_valid`=0, `top_addr`=0, `full`=0, `count`=0.
- `top_addr` = array[tos] when count>0, else 0. Zero latency; a `pop` consumer samples it in the same cycle.
- Priority per edge: reset > flush > push/pop.
- `flush`: `count`←0, `tos` unchanged. Simultaneous push/pop in that cycle are ignored.
- Push only:
  - `tos`←tos+1 (wrap), array[tos+1]←push_addr.
  - `count`←min(count+1, DEPTH).
  - If full, the oldest entry is silently overwritten (circular); overflow event.
- Pop only:
  - If count>0: `tos`←tos-1 (wrap), `count`←count-1.
  - If count==0: no state change; underflow event.
- Push and pop together (tail call / `jalr` from leaf):
  - array[tos]←push_addr.
  - `tos` and `count` unchanged.
  - If count==0, behaves as a plain push (count←1).
- Pop of the last entry makes `top_valid` 0 on the following cycle.
- Pointer arithmetic is unsigned modulo DEPTH. `count` never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro `RAS_STATS_EN`.
- Defined:
  - `overflow_cnt` increments on each push with full=1 and no pop.
  - `underflow_cnt` increments on each pop with count==0 and no push.
  - Both saturate at 16'hFFFF, clear on reset only (not on flush).
- Undefined: both ports driven constant 0; no counter flops synthesised.

Decomposition:
- Shared constants in `_const.v`:
  - `RAS_DEPTH_DEFAULT`.
  - `REG_RA` (31), used by decode to qualify `pop`.
- One natural sub-module, `sat_counter` (parameter W=16; inc, clk, rst_n, value), instantiated twice under `RAS_STATS_EN`.
- Pointer logic stays inline.

Test Plan:
- Reset then idle 3 cycles -> top_valid=0, count=0, full=0, top_addr=0.
- Push 0x100, 0x200, 0x300 on consecutive cycles -> count=3, top_addr=0x300. Pop -> top_addr=0x200 same cycle as the second pop request; three pops total -> count=0, top_valid=0.
- DEPTH=8: push 0x4..0x24 step 4 (9 pushes) -> full=1, count=8, top_addr=0x24. Eight pops return 0x24..0x8; 0x4 is lost. overflow_cnt=1 with RAS_STATS_EN.
- count=2 (top 0x40): push+pop with push_addr=0x80 -> count=2, top_addr=0x80. Next pop -> top_addr = previous lower entry.
- Empty stack: pop twice -> no state change, underflow_cnt=2 (RAS_STATS_EN) or 0 without. Then push 0x10 -> count=1.
- count=5: assert flush together with push -> count=0 next cycle, push ignored. Reset mid-sequence with rst_n low for 1 cycle -> all outputs at reset values.
